// File: rtl/mlp_seq_ctrl.sv
// Job sequencer for the MLP accelerator: counts load words, runs the clear/MAC/round
// passes on the pe_array, then drains the result bank to the output port.
module mlp_seq_ctrl #(
    parameter int unsigned W_WORDS    = 128,
    parameter int unsigned X_WORDS    = 128,
    parameter int unsigned K_LEN      = 16,
    parameter int unsigned N_ROUNDS   = 8,
    parameter int unsigned OUT_WORDS  = 128,
    parameter int unsigned RV_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en_i,
    output logic                          load_type_o,
    output logic                          pe_rst_o,
    output logic                          pe_en_o,
    output logic                          keep_o,
    output logic [$clog2(K_LEN)-1:0]      add_number_o,
    output logic                          rounder_en_o,
    output logic [$clog2(N_ROUNDS)-1:0]   round_number_o,
    input  logic                          rounder_valid_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [$clog2(OUT_WORDS)-1:0]  out_idx_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int unsigned KW   = $clog2(K_LEN);
    localparam int unsigned RW   = $clog2(N_ROUNDS);
    localparam int unsigned IW   = $clog2(OUT_WORDS);
    localparam int unsigned LMAX = (W_WORDS > X_WORDS) ? W_WORDS : X_WORDS;
    localparam int unsigned CW   = $clog2(LMAX + 1);
    localparam int unsigned TW   = $clog2(RV_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_W, LOAD_X, CLEAR, MAC, ROUND, WAIT_RV, OUTPUT, DONE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [KW-1:0]   k, k_n;
    logic [RW-1:0]   round, round_n;
    logic [TW-1:0]   tmo, tmo_n;
    logic [IW-1:0]   idx, idx_n;
    logic            err, err_n;

    // Next-state and counter update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        round_n = round;
        tmo_n   = tmo;
        idx_n   = idx;
        err_n   = err;
        if (load_en_i && !(state inside {IDLE, LOAD_W, LOAD_X}))
            err_n = 1'b1;
        case (state)
            IDLE: if (load_en_i) begin
                if (W_WORDS == 1) begin
                    state_n = LOAD_X;
                    cnt_n   = '0;
                end else begin
                    state_n = LOAD_W;
                    cnt_n   = CW'(1);
                end
            end
            LOAD_W: if (load_en_i) begin
                if (cnt == CW'(W_WORDS - 1)) begin
                    state_n = LOAD_X;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LOAD_X: if (load_en_i) begin
                if (cnt == CW'(X_WORDS - 1)) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CLEAR: begin
                state_n = MAC;
                k_n     = '0;
            end
            MAC: begin
                if (k == KW'(K_LEN - 1)) begin
                    state_n = ROUND;
                    k_n     = '0;
                end else begin
                    k_n = k + KW'(1);
                end
            end
            ROUND: begin
                state_n = WAIT_RV;
                tmo_n   = '0;
            end
            WAIT_RV: begin
                if (rounder_valid_i) begin
                    tmo_n = '0;
                    if (round == RW'(N_ROUNDS - 1)) begin
                        state_n = OUTPUT;
                        idx_n   = '0;
                        round_n = '0;
                    end else begin
                        state_n = CLEAR;
                        round_n = round + RW'(1);
                    end
                end else if (tmo == TW'(RV_TIMEOUT - 1)) begin
                    // Rounder never answered: abort the job
                    state_n = IDLE;
                    err_n   = 1'b1;
                    round_n = '0;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            OUTPUT: if (out_ready_i) begin
                if (idx == IW'(OUT_WORDS - 1)) begin
                    state_n = DONE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            k            <= '0;
            round        <= '0;
            tmo          <= '0;
            idx          <= '0;
            err          <= 1'b0;
            load_type_o  <= 1'b0;
            pe_rst_o     <= 1'b0;
            pe_en_o      <= 1'b0;
            keep_o       <= 1'b0;
            rounder_en_o <= 1'b0;
            out_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            k            <= k_n;
            round        <= round_n;
            tmo          <= tmo_n;
            idx          <= idx_n;
            err          <= err_n;
            load_type_o  <= (state_n == LOAD_X);
            pe_rst_o     <= (state_n == CLEAR);
            pe_en_o      <= (state_n == MAC);
            keep_o       <= (state_n == MAC) && (k_n != '0);
            rounder_en_o <= (state_n == ROUND);
            out_valid_o  <= (state_n == OUTPUT);
            busy_o       <= (state_n != IDLE);
            done_o       <= (state_n == DONE);
        end
    end

    assign add_number_o   = k;
    assign round_number_o = round;
    assign out_idx_o      = idx;
    assign err_o          = err;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl: stimulus queues expected events, a negedge monitor
// pops and compares them as the sequencer emits strobes.
module tb_mlp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en_i;
    logic       load_type_o;
    logic       pe_rst_o;
    logic       pe_en_o;
    logic       keep_o;
    logic [3:0] add_number_o;
    logic       rounder_en_o;
    logic [2:0] round_number_o;
    logic       rounder_valid_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [6:0] out_idx_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    mlp_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .load_en_i       (load_en_i),
        .load_type_o     (load_type_o),
        .pe_rst_o        (pe_rst_o),
        .pe_en_o         (pe_en_o),
        .keep_o          (keep_o),
        .add_number_o    (add_number_o),
        .rounder_en_o    (rounder_en_o),
        .round_number_o  (round_number_o),
        .rounder_valid_i (rounder_valid_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_idx_o       (out_idx_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int q_lt[$];
    int q_clr[$];
    int q_mac[$];
    int q_rnd[$];
    int q_out[$];
    int q_done[$];

    bit rv_auto  = 1'b1;
    bit rdy_mode = 1'b0;
    bit stray    = 1'b0;
    bit prev_stall = 1'b0;
    int prev_idx   = 0;
    int last_rnd   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Ready pattern 1,0,0,1 when stalling, else always ready
    int ph = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            out_ready_i = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end else begin
            out_ready_i = 1'b1;
        end
    end

    // Rounder model: valid one cycle after rounder_en
    always @(negedge clk) begin
        if (rv_auto && rounder_en_o && !rst) begin
            @(posedge clk); #1 rounder_valid_i = 1'b1;
            @(posedge clk); #1 rounder_valid_i = 1'b0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        int e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (load_en_i) begin
                if (q_lt.size() == 0) unexpected("load_type");
                else begin e = q_lt.pop_front(); chk("load_type", int'(load_type_o), e); end
            end
            if (pe_rst_o) begin
                if (q_clr.size() == 0) unexpected("pe_rst");
                else begin e = q_clr.pop_front(); chk("pe_rst_round", int'(round_number_o), e); end
            end
            if (pe_en_o) begin
                if (q_mac.size() == 0) unexpected("pe_en");
                else begin
                    e = q_mac.pop_front();
                    chk("mac_round_add_keep", int'({round_number_o, add_number_o, keep_o}), e);
                end
            end
            if (rounder_en_o) begin
                if (q_rnd.size() == 0) unexpected("rounder_en");
                else begin e = q_rnd.pop_front(); chk("rounder_en_round", int'(round_number_o), e); end
                if (round_number_o != 3'd0) chk("round_period", cyc - last_rnd, 19);
                last_rnd = cyc;
            end
            if (prev_stall) begin
                chk("stall_hold_valid", int'(out_valid_o), 1);
                chk("stall_hold_idx", int'(out_idx_o), prev_idx);
            end
            if (out_valid_o && out_ready_i) begin
                if (q_out.size() == 0) unexpected("out_xfer");
                else begin e = q_out.pop_front(); chk("out_idx", int'(out_idx_o), e); end
            end
            if (done_o) begin
                if (q_done.size() == 0) unexpected("done");
                else begin e = q_done.pop_front(); chk("done_busy", int'(busy_o), e); end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_idx   = int'(out_idx_o);
        end
    end

    task automatic push_round(input int r);
        q_clr.push_back(r);
        for (int k = 0; k < 16; k++) q_mac.push_back((r << 5) | (k << 1) | int'(k != 0));
        q_rnd.push_back(r);
    endtask

    task automatic push_job();
        for (int r = 0; r < 8; r++) push_round(r);
        for (int i = 0; i < 128; i++) q_out.push_back(i);
        q_done.push_back(1);
    endtask

    // 256 back-to-back words; CLEAR must follow word 255 and MAC the cycle after
    task automatic load_all();
        for (int i = 0; i < 256; i++) q_lt.push_back(int'(i >= 128));
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1 load_en_i = 1'b1;
        end
        @(posedge clk); #1 load_en_i = 1'b0;
        @(negedge clk);
        chk("pe_rst_after_last_word", int'(pe_rst_o), 1);
        @(negedge clk);
        chk("first_pe_en_latency", int'(pe_en_o), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stray && pe_en_o && round_number_o == 3'd2) begin
                q_lt.push_back(0);
                @(posedge clk); #1 load_en_i = 1'b1;
                @(posedge clk); #1 load_en_i = 1'b0;
                stray = 1'b0;
            end
            if (!busy_o) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s: busy still high after %0d cycles", name, budget);
        end
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_lt_left"},   q_lt.size(),   0);
        chk({tag, "_clr_left"},  q_clr.size(),  0);
        chk({tag, "_mac_left"},  q_mac.size(),  0);
        chk({tag, "_rnd_left"},  q_rnd.size(),  0);
        chk({tag, "_out_left"},  q_out.size(),  0);
        chk({tag, "_done_left"}, q_done.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outputs"}, int'({load_type_o, pe_rst_o, pe_en_o, keep_o, add_number_o,
            rounder_en_o, round_number_o, out_valid_o, out_idx_o, done_o, err_o}), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        rst = 1'b1; load_en_i = 1'b0; rounder_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Full job, ready always high
        push_job();
        load_all();
        wait_idle("job_ready", 3000);
        check_drained("job_ready");
        chk("job_ready_err", int'(err_o), 0);

        // Output with ready pattern 1,0,0,1
        rdy_mode = 1'b1;
        push_job();
        load_all();
        wait_idle("job_stall", 4000);
        rdy_mode = 1'b0;
        check_drained("job_stall");

        // Rounder never answers: abort after the timeout window
        rv_auto = 1'b0;
        push_round(0);
        load_all();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rounder_en_o) begin seen = 1'b1; break; end
            end
            chk("tmo_rounder_en_seen", int'(seen), 1);
        end
        repeat (64) @(negedge clk);
        chk("tmo_err_not_yet", int'(err_o), 0);
        chk("tmo_busy_not_yet", int'(busy_o), 1);
        @(negedge clk);
        chk("tmo_err_set", int'(err_o), 1);
        chk("tmo_idle", int'(busy_o), 0);
        rv_auto = 1'b1;
        check_drained("tmo");

        // New job after abort runs normally with error still sticky
        push_job();
        load_all();
        wait_idle("job_after_tmo", 3000);
        check_drained("job_after_tmo");
        chk("err_sticky", int'(err_o), 1);

        // Reset in the middle of round 3 MAC
        push_job();
        load_all();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (pe_en_o && round_number_o == 3'd3) begin seen = 1'b1; break; end
            end
            chk("abort_round3_reached", int'(seen), 1);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        q_lt.delete(); q_clr.delete(); q_mac.delete();
        q_rnd.delete(); q_out.delete(); q_done.delete();

        // Stray load word during MAC: flagged, sequencing unaffected
        push_job();
        load_all();
        chk("stray_err_before", int'(err_o), 0);
        stray = 1'b1;
        wait_idle("job_stray", 3000);
        chk("stray_injected", int'(stray), 0);
        chk("stray_err_set", int'(err_o), 1);
        check_drained("job_stray");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
